// File: rtl/block_interleaver_pkg.sv
// Shared types and constants for the block interleaver receive-side framing logic.
package block_interleaver_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEND       = 2'd1,
    DRAIN_LOW  = 2'd2,
    DRAIN_HIGH = 2'd3
  } cw_state_e;

  localparam int MIN_CW_LENGTH = 2;

  function automatic int len_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/block_cw_framer.sv
// Frames an unframed symbol stream into codewords of per-codeword length for the
// block interleaver, honouring its ready/drain handshake and error abort.
module block_cw_framer
  import block_interleaver_pkg::*;
#(
  parameter int NUMBER_OF_ELEMENTS = 12,
  parameter int WORD_LENGTH        = 3,
  localparam int LW                = len_width(NUMBER_OF_ELEMENTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic [WORD_LENGTH-1:0] i_data,
  input  logic [LW-1:0]          i_cw_length,
  output logic                   o_consume,
  input  logic                   i_in_ready,
  input  logic                   i_error,
  output logic                   o_valid,
  output logic                   o_start_cw,
  output logic                   o_end_cw,
  output logic [WORD_LENGTH-1:0] o_data,
  output logic                   o_error
);

  cw_state_e             state, state_n;
  logic [LW-1:0]         remaining, remaining_n;
  logic                  len_ok, take, consume, illegal;

  logic                  vld_p1, start_p1, end_p1, err_p1;
  logic [WORD_LENGTH-1:0] data_p1;

  always_comb begin
    len_ok  = (i_cw_length >= LW'(MIN_CW_LENGTH)) &&
              (i_cw_length <= LW'(NUMBER_OF_ELEMENTS));
    take    = i_valid && i_in_ready && !i_error;
    consume = 1'b0;
    illegal = 1'b0;
    case (state)
      IDLE: begin
        consume = take && len_ok;
        illegal = i_valid && i_in_ready && !len_ok;
      end
      SEND:    consume = take && (remaining != '0);
      default: ;
    endcase
  end

  assign o_consume = consume;

  // Abort from the interleaver overrides every transition and clears the count.
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    if (i_error) begin
      state_n     = IDLE;
      remaining_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (consume) begin
            state_n     = SEND;
            remaining_n = i_cw_length - LW'(1);
          end
        end
        SEND: begin
          if (consume) begin
            remaining_n = remaining - LW'(1);
            if (remaining == LW'(1)) state_n = DRAIN_LOW;
          end
        end
        DRAIN_LOW:  if (!i_in_ready) state_n = DRAIN_HIGH;
        DRAIN_HIGH: if (i_in_ready)  state_n = IDLE;
        default:    state_n = IDLE;
      endcase
    end
  end

  // p1: one-cycle output stage toward the interleaver.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      vld_p1    <= 1'b0;
      start_p1  <= 1'b0;
      end_p1    <= 1'b0;
      err_p1    <= 1'b0;
      data_p1   <= '0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      vld_p1    <= consume;
      start_p1  <= consume && (state == IDLE);
      end_p1    <= consume && (state == SEND) && (remaining == LW'(1));
      err_p1    <= i_error || illegal;
      if (consume) data_p1 <= i_data;
    end
  end

  assign o_valid    = vld_p1;
  assign o_start_cw = start_p1;
  assign o_end_cw   = end_p1;
  assign o_error    = err_p1;
  assign o_data     = data_p1;

endmodule

// File: tb/tb_block_cw_framer.sv
// Directed table-driven bench for block_cw_framer, plus a hand-written drain-gap sequence.
module tb_block_cw_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_valid = 1'b0;
  logic [2:0] i_data = '0;
  logic [3:0] i_cw_length = '0;
  logic       o_consume;
  logic       i_in_ready = 1'b0;
  logic       i_error = 1'b0;
  logic       o_valid, o_start_cw, o_end_cw, o_error;
  logic [2:0] o_data;

  int tests = 0;
  int fails = 0;

  block_cw_framer #(.NUMBER_OF_ELEMENTS(12), .WORD_LENGTH(3)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
    .i_cw_length(i_cw_length), .o_consume(o_consume), .i_in_ready(i_in_ready),
    .i_error(i_error), .o_valid(o_valid), .o_start_cw(o_start_cw),
    .o_end_cw(o_end_cw), .o_data(o_data), .o_error(o_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, vld, rdy, err;
    logic [2:0] data;
    logic [3:0] len;
    logic       e_cons, e_vld, e_start, e_end, e_err;
    logic [2:0] e_data;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic v, input logic [2:0] d, input logic [3:0] l,
                     input logic rd, input logic er, input logic ec, input logic ev,
                     input logic es, input logic ee, input logic [2:0] ed, input logic eer);
    vec_t t;
    t.rst = r; t.vld = v; t.data = d; t.len = l; t.rdy = rd; t.err = er;
    t.e_cons = ec; t.e_vld = ev; t.e_start = es; t.e_end = ee; t.e_data = ed; t.e_err = eer;
    vq.push_back(t);
  endtask

  // A consumed symbol: presented next cycle with the given flags.
  task automatic sym(input logic [2:0] d, input logic [3:0] l, input logic s, input logic e);
    add(1'b0, 1'b1, d, l, 1'b1, 1'b0, 1'b1, 1'b1, s, e, d, 1'b0);
  endtask

  task automatic quiet(input logic v, input logic rd);
    add(1'b0, v, 3'd0, 4'd0, rd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic drain();
    quiet(1'b0, 1'b0);
    quiet(1'b0, 1'b1);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int gap;

    // reset
    add(1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    quiet(1'b0, 1'b1);
    // nominal L=12, data 0..11 truncated to 3 bits
    for (int k = 0; k < 12; k++) sym(3'(k), 4'd12, k == 0, k == 11);
    quiet(1'b1, 1'b1);
    for (int k = 0; k < 20; k++) quiet(1'b1, 1'b0);
    quiet(1'b1, 1'b1);
    sym(3'd5, 4'd3, 1'b1, 1'b0);
    sym(3'd6, 4'd3, 1'b0, 1'b0);
    sym(3'd7, 4'd3, 1'b0, 1'b1);
    drain();
    // illegal lengths
    add(1'b0, 1'b1, 3'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    add(1'b0, 1'b1, 3'd0, 4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    add(1'b0, 1'b1, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    add(1'b0, 1'b1, 3'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    sym(3'd4, 4'd2, 1'b1, 1'b0);
    sym(3'd3, 4'd2, 1'b0, 1'b1);
    drain();
    // valid gaps, L=5
    sym(3'd1, 4'd5, 1'b1, 1'b0);
    quiet(1'b0, 1'b1);
    sym(3'd2, 4'd5, 1'b0, 1'b0);
    sym(3'd3, 4'd5, 1'b0, 1'b0);
    quiet(1'b0, 1'b1);
    quiet(1'b0, 1'b1);
    sym(3'd4, 4'd5, 1'b0, 1'b0);
    sym(3'd5, 4'd5, 1'b0, 1'b1);
    drain();
    // downstream abort on 4th symbol of L=8
    sym(3'd0, 4'd8, 1'b1, 1'b0);
    sym(3'd1, 4'd8, 1'b0, 1'b0);
    sym(3'd2, 4'd8, 1'b0, 1'b0);
    add(1'b0, 1'b1, 3'd3, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    sym(3'd6, 4'd8, 1'b1, 1'b0);
    add(1'b0, 1'b0, 3'd0, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    // illegal length together with abort: one pulse
    add(1'b0, 1'b1, 3'd0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    quiet(1'b0, 1'b1);
    // reset mid-codeword, silent abandon
    sym(3'd1, 4'd4, 1'b1, 1'b0);
    sym(3'd2, 4'd4, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b1, 1'b0, 3'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    sym(3'd3, 4'd2, 1'b1, 1'b0);
    sym(3'd4, 4'd2, 1'b0, 1'b1);
    drain();

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = vq[i].rst; i_valid = vq[i].vld; i_data = vq[i].data;
      i_cw_length = vq[i].len; i_in_ready = vq[i].rdy; i_error = vq[i].err;
      #1;
      check($sformatf("v%0d consume", i), o_consume, vq[i].e_cons);
      @(posedge clk);
      #1;
      check($sformatf("v%0d valid", i), o_valid, vq[i].e_vld);
      check($sformatf("v%0d start_cw", i), o_start_cw, vq[i].e_start);
      check($sformatf("v%0d end_cw", i), o_end_cw, vq[i].e_end);
      check($sformatf("v%0d error", i), o_error, vq[i].e_err);
      if (vq[i].e_vld || vq[i].rst)
        check($sformatf("v%0d data", i), o_data, vq[i].e_data);
    end

    // Minimum end_cw to start_cw gap when the interleaver drains immediately.
    @(negedge clk);
    rst = 1'b0; i_valid = 1'b1; i_in_ready = 1'b1; i_error = 1'b0; i_cw_length = 4'd2;
    @(posedge clk); #1;
    check("gap start_cw", o_start_cw, 1);
    @(negedge clk);
    @(posedge clk); #1;
    check("gap end_cw", o_end_cw, 1);
    gap = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      i_in_ready = (k == 1) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      if (o_start_cw) begin
        gap = k;
        break;
      end
    end
    check("end_to_start_gap", gap, 3);
    @(negedge clk);
    i_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/block_cw_framer.md
# block_cw_framer

Codeword framer that drives the receive side of the block interleaver/deinterleaver. It takes an unframed symbol stream plus a per-codeword length and emits symbols with `o_start_cw`/`o_end_cw` framing. It never violates the interleaver input protocol: no 1-symbol codewords, no overflow, no symbol while the interleaver is not ready. It sits directly upstream of the interleaver in the FEC chain.

## Interface
- NUMBER_OF_ELEMENTS, 12, interleaver capacity in symbols; maximum legal codeword length.
- WORD_LENGTH, 3, symbol width.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  upstream symbol available.
- i_data  in  WORD_LENGTH  upstream symbol.
- i_cw_length  in  $clog2(NUMBER_OF_ELEMENTS+1)  length of the next codeword; sampled only at codeword start.
- o_consume  out  1  combinational; upstream symbol taken this cycle.
- i_in_ready  in  1  interleaver ready to receive.
- i_error  in  1  interleaver error flag.
- o_valid  out  1  registered; symbol presented to interleaver.
- o_start_cw  out  1  registered; first symbol of codeword, only with o_valid.
- o_end_cw  out  1  registered; last symbol of codeword, only with o_valid.
- o_data  out  WORD_LENGTH  registered symbol.
- o_error  out  1  registered one-cycle pulse: illegal length or downstream abort.

## Operation
- States: IDLE, SEND, DRAIN_LOW, DRAIN_HIGH.
- **IDLE.** When i_valid && i_in_ready, sample L = i_cw_length.
  - L < 2 or L > NUMBER_OF_ELEMENTS: pulse o_error, o_consume=0, stay IDLE. The length is re-sampled every cycle.
  - Legal L: o_consume=1; next cycle o_valid=1, o_start_cw=1, o_end_cw=0. Counter remaining = L-1; go to SEND.
- **SEND.** o_consume = i_valid && i_in_ready.
  - On each consume: o_valid=1 next cycle with the symbol, and remaining decrements.
  - Consume with remaining==1: next-cycle o_end_cw=1; go to DRAIN_LOW.
  - Gaps in i_valid produce o_valid=0 cycles. The codeword continues; no flags are emitted in gap cycles.
- **DRAIN_LOW.** Wait for i_in_ready==0, meaning the interleaver is in transmit mode. No consume.
- **DRAIN_HIGH.** Wait for i_in_ready==1, meaning the interleaver has emptied; then go to IDLE. No consume.
- **o_start_cw/o_end_cw.** Never asserted without o_valid, and never both in the same cycle, since L≥2.
- **i_error==1 in any state.**
  - Next state IDLE, counter cleared, o_consume=0 that cycle.
  - Next cycle: o_valid/o_start_cw/o_end_cw = 0 and o_error=1.
  - i_error has priority over every other transition.
- **Illegal length and i_error in the same cycle.** A single o_error pulse.
- **Arithmetic.** Counter is unsigned, width $clog2(NUMBER_OF_ELEMENTS+1), and never wraps: it decrements only in SEND while remaining ≥1.

## Timing
- **Reset.** rst sampled high leaves, in the following cycle: state IDLE, counter 0, o_valid=0, o_start_cw=0, o_end_cw=0, o_error=0, o_data=0, o_consume=0. A reset mid-codeword abandons the codeword silently, with no o_error.
- **Latency.** Exactly one cycle from consume (cycle T) to o_valid/o_data at the interleaver (cycle T+1).
- **o_consume.** Combinational from i_valid, i_in_ready, state, counter and i_error. It is never asserted in DRAIN_LOW or DRAIN_HIGH.
- **Ready sampling.** i_in_ready is sampled in the consume cycle. The interleaver holds in_ready high while receiving, so the one-cycle output delay is safe.
- **Drain.** The interleaver drops in_ready the cycle after it receives end_cw. DRAIN_LOW is therefore normally left one cycle after o_end_cw is presented. The minimum gap from o_end_cw to the next o_start_cw is 3 cycles.

## Structure
- **Shared package (block_interleaver_pkg):**
  - state enum (IDLE, SEND, DRAIN_LOW, DRAIN_HIGH);
  - length-width function $clog2(NUMBER_OF_ELEMENTS+1);
  - MIN_CW_LENGTH = 2.
- **Sub-module:** none. A single module: state register, down-counter, output register stage.

## Test plan
- **Reset.** rst=1 for 2 cycles mid-SEND → all outputs 0 the next cycle, state IDLE, no o_error.
- **Nominal codeword.** L=12, i_valid constant, i_in_ready high, data 0..11 → o_valid 12 cycles, start_cw with data 0, end_cw with data 11, o_consume deasserts after 12.
- **Drain, then second codeword.** After end_cw, hold i_in_ready low 20 cycles with i_valid high → no consume, no o_valid. Raise i_in_ready → next start_cw one cycle after the first consume.
- **Illegal length.** L=1, then L=13, i_valid high → o_error pulse each cycle, no o_valid, no consume. Then L=2 → 2-symbol codeword, start then end.
- **Valid gaps.** L=5, i_valid pattern 1,0,1,1,0,0,1,1 → o_valid follows with a 1-cycle delay, end_cw on the 5th symbol only, no flags in gaps.
- **Downstream abort.** i_error=1 on the 4th symbol of L=8 → no consume that cycle, o_error=1 next cycle, state IDLE. The next symbol starts a new codeword with start_cw.
